time_mux_scanner: RTL

TIME_MUX_SCANNER -- requirements
Module: time_mux_scanner

---
 rtl/time_mux_scanner.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/time_mux_scanner.sv
// Time-multiplexed 7-segment scanner: walks NUM_DIGITS digit slots of
// 16 PWM sub-ticks each, decodes hex with optional leading-zero blanking,
// and double-buffers display data so updates land on frame boundaries.
module time_mux_scanner #(
  parameter int NUM_DIGITS         = 5,
  parameter int SUB_DIV            = 6250,
  parameter int ANODE_ACTIVE_LOW   = 1,
  parameter int CATHODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [3:0]              duty,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(SUB_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
  localparam logic [7:0]            CA_OFF     = {8{CATHODE_ACTIVE_LOW != 0}};

  logic [PW-1:0]           r_presc;
  logic [3:0]              r_sub;
  logic [IW-1:0]           r_idx;
  logic                    r_frame_tick;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_sh_dig;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic                    r_sh_lz;
  logic [4*NUM_DIGITS-1:0] r_act_dig;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic                    r_act_lz;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [7:0]              r_cathode;

  logic                    w_sub_adv;
  logic                    w_idx_adv;
  logic                    w_boundary;
  logic [NUM_DIGITS-1:0]   w_supp;
  logic                    w_zrun;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic                    w_supp_cur;
  logic [6:0]              w_seg;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [7:0]              w_cat;

  assign w_sub_adv  = (r_presc == PRESC_LAST);
  assign w_idx_adv  = w_sub_adv && (r_sub == 4'hF);
  assign w_boundary = w_idx_adv && (r_idx == IDX_LAST);

  assign anode      = r_anode;
  assign cathode    = r_cathode;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

  // Prescaler, sub-tick and scan index counters plus the frame pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc      <= '0;
      r_sub        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_sub_adv ? '0 : r_presc + PW'(1);
      r_frame_tick <= w_boundary;
      if (w_sub_adv) begin
        r_sub <= r_sub + 4'd1;
      end
      if (w_idx_adv) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
    end
  end

  // Shadow/active double buffer: a load on the boundary bypasses the
  // shadow so it is never left pending behind its own commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending   <= 1'b0;
      r_sh_dig    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_sh_lz     <= 1'b0;
      r_act_dig   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_act_lz    <= 1'b0;
    end else if (w_boundary && load) begin
      r_sh_dig    <= digits_in;
      r_sh_dp     <= dp_in;
      r_sh_blank  <= blank_in;
      r_sh_lz     <= lz_en;
      r_act_dig   <= digits_in;
      r_act_dp    <= dp_in;
      r_act_blank <= blank_in;
      r_act_lz    <= lz_en;
      r_pending   <= 1'b0;
    end else if (w_boundary) begin
      if (r_pending) begin
        r_act_dig   <= r_sh_dig;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
        r_act_lz    <= r_sh_lz;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_sh_dig   <= digits_in;
      r_sh_dp    <= dp_in;
      r_sh_blank <= blank_in;
      r_sh_lz    <= lz_en;
      r_pending  <= 1'b1;
    end
  end

  // Leading-zero mask: digit i is suppressed while every digit from the top
  // down to i is zero; digit 0 is always shown.
  always_comb begin
    w_supp = '0;
    w_zrun = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zrun    = w_zrun && (r_act_dig[4*i +: 4] == 4'h0);
      w_supp[i] = r_act_lz && w_zrun;
    end
  end

  // Select the scanned digit's nibble and attributes from the active set.
  always_comb begin
    w_nib      = 4'h0;
    w_dp       = 1'b0;
    w_blank    = 1'b0;
    w_supp_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib      = r_act_dig[4*i +: 4];
        w_dp       = r_act_dp[i];
        w_blank    = r_act_blank[i];
        w_supp_cur = w_supp[i];
      end
    end
  end

  // Hex to gfedcba decode, active-high.
  always_comb begin
    w_seg = 7'h00;
    case (w_nib)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      default: w_seg = 7'h71;
    endcase
  end

  // PWM gating and active-high anode/cathode before polarity.
  always_comb begin
    w_lit = (r_sub <= duty) && !w_blank;
    w_an  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_an[i] = w_lit && (r_idx == IW'(i));
    end
    w_cat = {w_dp, (w_supp_cur ? 7'h00 : w_seg)};
    if (!w_lit) begin
      w_cat = '0;
    end
  end

  // Output registers; polarity applied as a final XOR with the off level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_anode   <= AN_OFF;
      r_cathode <= CA_OFF;
    end else begin
      r_anode   <= w_an ^ AN_OFF;
      r_cathode <= w_cat ^ CA_OFF;
    end
  end

endmodule
